// File: rtl/mux_rr_pkg.sv
// Shared constants and helpers for the round-robin registered multiplexer.
//   N_CH_DEF   : default channel count
//   DATA_W_DEF : default data width per channel
//   ch_w_f()   : channel-index width, never narrower than one bit
package mux_rr_pkg;

  localparam int unsigned N_CH_DEF   = 4;
  localparam int unsigned DATA_W_DEF = 3;

  function automatic int unsigned ch_w_f(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_sched_if.sv
// Producer/consumer handshake bundle for mux_rr_sched.
//   in_data/in_valid/in_ready : N_CH producer channels (flattened data)
//   out_data/out_ch/out_valid/out_ready : single consumer side
//   master : environment side, slave : scheduler side
interface mux_rr_sched_if
  import mux_rr_pkg::*;
#(
  parameter int unsigned N_CH   = N_CH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  localparam int unsigned CH_W = ch_w_f(N_CH);

  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_ready;
  logic [DATA_W-1:0]      out_data;
  logic [CH_W-1:0]        out_ch;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority search.
//   req       : per-channel request
//   ptr       : channel with highest priority this cycle
//   found     : at least one request present
//   grant_idx : first requesting channel at or after ptr (wrapping)
//   grant_oh  : one-hot form of grant_idx, zero when nothing found
module rr_arbiter
  import mux_rr_pkg::*;
#(
  parameter int unsigned N_CH = N_CH_DEF,
  parameter int unsigned CH_W = ch_w_f(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic            found,
  output logic [CH_W-1:0] grant_idx,
  output logic [N_CH-1:0] grant_oh
);

  // Walk channels ptr, ptr+1, ... modulo N_CH; first hit wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found && req[CH_W'((32'(ptr) + i) % N_CH)]) begin
        found     = 1'b1;
        grant_idx = CH_W'((32'(ptr) + i) % N_CH);
      end
    end
    grant_oh = found ? (N_CH'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/mux_rr_sched.sv
// N-channel round-robin scheduler feeding one registered output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mux_rr_sched_if slave (producer channels + consumer side)
//   force_en, force_sel : present only with MUX_RR_FORCE_EN defined; pin the
//                         grant candidate to force_sel without moving rr_ptr
module mux_rr_sched
  import mux_rr_pkg::*;
#(
  parameter int unsigned N_CH   = N_CH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned CH_W  = ch_w_f(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef MUX_RR_FORCE_EN
  input  logic            force_en,
  input  logic [CH_W-1:0] force_sel,
`endif
  mux_rr_sched_if.slave   bus
);

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [CH_W-1:0]   rr_ptr_q;

  logic              rr_found_c;
  logic [CH_W-1:0]   rr_idx_c;
  logic [N_CH-1:0]   rr_oh_c;
  logic              g_found_c;
  logic [CH_W-1:0]   g_idx_c;
  logic [N_CH-1:0]   rdy_c;
  logic              adv_c;
  logic              free_c;
  logic              grant_c;
  logic [CH_W-1:0]   nxt_ptr_c;

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (rr_ptr_q),
    .found     (rr_found_c),
    .grant_idx (rr_idx_c),
    .grant_oh  (rr_oh_c)
  );

  // Grant selection; a forced grant bypasses the arbiter and leaves rr_ptr alone.
  always_comb begin
    g_found_c = rr_found_c;
    g_idx_c   = rr_idx_c;
    rdy_c     = rr_oh_c;
    adv_c     = 1'b1;
`ifdef MUX_RR_FORCE_EN
    if (force_en) begin
      adv_c     = 1'b0;
      g_idx_c   = force_sel;
      g_found_c = (32'(force_sel) < N_CH) && bus.in_valid[force_sel];
      rdy_c     = N_CH'(1) << force_sel;
    end
`endif
    free_c  = !out_valid_q || bus.out_ready;
    grant_c = free_c && g_found_c;
  end

  assign nxt_ptr_c    = (g_idx_c == CH_W'(N_CH - 1)) ? '0 : g_idx_c + CH_W'(1);
  assign bus.in_ready = grant_c ? rdy_c : '0;

  // Output stage: a grant (re)loads it, a pop without refill empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else if (grant_c) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data[32'(g_idx_c)*DATA_W +: DATA_W];
      out_ch_q    <= g_idx_c;
      if (adv_c) begin
        rr_ptr_q <= nxt_ptr_c;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench for mux_rr_sched: directed scenarios plus a randomized
// run, all compared against a transaction-level scheduler model.
module tb_mux_rr_sched;
  import mux_rr_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 3;
  localparam int unsigned CW = ch_w_f(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          f_en = 1'b0;
  logic [CW-1:0] f_sel = '0;

  mux_rr_sched_if #(.N_CH(N), .DATA_W(DW)) bus ();

  mux_rr_sched #(
    .N_CH   (N),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MUX_RR_FORCE_EN
    .force_en  (f_en),
    .force_sel (f_sel),
`endif
    .bus       (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: contents of the output stage and the next channel in turn.
  bit m_valid;
  int m_data;
  int m_ch;
  int m_ptr;
  bit e_found;
  int e_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = 0;
    m_ch    = 0;
    m_ptr   = 0;
  endfunction

  // Which channel should be accepted this cycle, if any.
  function automatic void predict();
    e_found = 1'b0;
    e_g     = 0;
    if (m_valid && !bus.out_ready) return;
    if (f_en) begin
      if (int'(f_sel) < N && bus.in_valid[f_sel]) begin
        e_found = 1'b1;
        e_g     = int'(f_sel);
      end
      return;
    end
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (bus.in_valid[c]) begin
        e_found = 1'b1;
        e_g     = c;
        return;
      end
    end
  endfunction

  // One clock: check in_ready, apply the edge to the model, check outputs.
  // Entered and left at a falling edge.
  task automatic cycle();
    #1;
    predict();
    chk("in_ready", 32'(bus.in_ready), e_found ? (32'd1 << e_g) : 32'd0);
    @(posedge clk);
    if (e_found) begin
      m_valid = 1'b1;
      m_data  = int'(bus.in_data[e_g*DW +: DW]);
      m_ch    = e_g;
      if (!f_en) m_ptr = (e_g + 1) % N;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_data", 32'(bus.out_data), 32'(m_data));
    chk("out_ch", 32'(bus.out_ch), 32'(m_ch));
    @(negedge clk);
  endtask

  task automatic set_ch(input int k, input logic v, input logic [DW-1:0] d);
    bus.in_valid[k]          = v;
    bus.in_data[k*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load a word, then reset asynchronously in mid-cycle.
    set_ch(1, 1'b1, 3'h5);
    cycle();
    chk("t1_loaded", 32'(bus.out_valid), 32'd1);
    set_ch(1, 1'b0, 3'h0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t1_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_async_data", 32'(bus.out_data), 32'd0);
    chk("t1_async_ch", 32'(bus.out_ch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_ch(0, 1'b1, 3'h2);
    bus.out_ready = 1'b1;
    cycle();
    chk("t1_data", 32'(bus.out_data), 32'h2);
    chk("t1_ch", 32'(bus.out_ch), 32'd0);

    // Round-robin order with every channel requesting.
    do_reset();
    set_ch(0, 1'b1, 3'h2);
    set_ch(1, 1'b1, 3'h1);
    set_ch(2, 1'b1, 3'h3);
    set_ch(3, 1'b1, 3'h6);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t2_seq", 32'(bus.out_ch), 32'(i % 4));
    end

    // Backpressure holds the stage; release resumes after the held channel.
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0110;
    repeat (3) cycle();
    chk("t3_hold_ch", 32'(bus.out_ch), 32'd0);
    chk("t3_hold_data", 32'(bus.out_data), 32'h2);
    bus.out_ready = 1'b1;
    cycle();
    chk("t3_next", 32'(bus.out_ch), 32'd1);

    // Sparse requests with pointer at 3: wrap to 0, skip idle channels.
    bus.in_valid = 4'b0100;
    cycle();
    bus.in_valid = 4'b0101;
    cycle();
    chk("t4_g0", 32'(bus.out_ch), 32'd0);
    cycle();
    chk("t4_g1", 32'(bus.out_ch), 32'd2);
    cycle();
    chk("t4_g2", 32'(bus.out_ch), 32'd0);

    // Pop without refill.
    bus.in_valid = 4'b0000;
    cycle();
    chk("t5_empty", 32'(bus.out_valid), 32'd0);
    chk("t5_hold_ch", 32'(bus.out_ch), 32'd0);
    chk("t5_hold_data", 32'(bus.out_data), 32'h2);

`ifdef MUX_RR_FORCE_EN
    // Forced grants to channel 2 leave the pointer (1) untouched.
    bus.in_valid = 4'b1111;
    f_en  = 1'b1;
    f_sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_forced", 32'(bus.out_ch), 32'd2);
    end
    f_en = 1'b0;
    cycle();
    chk("t6_resume", 32'(bus.out_ch), 32'd1);
`endif

    // Randomized traffic; producers hold a word until it is accepted.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < N; k++) begin
        if (!bus.in_valid[k] || (e_found && e_g == k))
          set_ch(k, 1'($urandom_range(0, 1)), DW'($urandom));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_RR_FORCE_EN
      f_en  = ($urandom_range(0, 7) == 0);
      f_sel = CW'($urandom);
`endif
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_rr_sched.md
Name: mux_rr_sched

Overview:
Parametrised N-channel, W-bit registered multiplexer. It is the sequential successor to the 2-bit-select combinational mux.
- Replaces the external `sel` with an internal round-robin arbiter over per-channel valid/ready handshakes.
- Drives one registered output stage with its own valid/ready handshake.
- Sits between several producers and a single consumer, e.g. shared display or ALU input.

Parameters:
- N_CH, 4, number of input channels (>=2)
- DATA_W, 3, data width per channel
- CH_W, $clog2(N_CH), width of the channel-index output (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N_CH*DATA_W  flattened channel data; channel k occupies bits [k*DATA_W +: DATA_W]
- in_valid  input  N_CH  per-channel request
- in_ready  output  N_CH  per-channel accept, one-hot or zero
- out_data  output  DATA_W  registered selected data
- out_ch  output  CH_W  index of the channel that supplied out_data
- out_valid  output  1  output stage holds a word
- out_ready  input  1  consumer accepts the word

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready is combinational and is therefore 0 while out_valid=0 and no in_valid is set.
- Stage free: free = !out_valid | out_ready.
- Grant: combinational search starting at rr_ptr, wrapping modulo N_CH, for the first channel with in_valid=1.
  - in_ready[g] = free & found; all other in_ready bits = 0.
- Transfer on a channel when in_valid & in_ready on the same edge.
  - out_data <= in_data[g]; out_ch <= g; out_valid <= 1; rr_ptr <= (g+1) mod N_CH.
- Consumer pop with no new grant (out_valid & out_ready, nothing granted): out_valid <= 0; out_data and out_ch hold their last value.
- Simultaneous pop and grant: the new word replaces the old one in the same cycle. Throughput is one word per cycle with no bubble.
- Backpressure (out_valid & !out_ready): all in_ready=0; out_data, out_ch and rr_ptr hold.
- Latency: one cycle from accepting transfer to out_valid.
- Source rule: a producer holds in_data/in_valid stable until accepted. The block never drops an accepted word.
- No valid inputs: rr_ptr holds (pointer advances only on a grant).
- Wrap-around: a grant to channel N_CH-1 sets rr_ptr=0.
- Fairness: with all channels continuously valid and out_ready=1, grants follow 0,1,...,N_CH-1,0,...
- Reset mid-operation: the stored word is discarded (out_valid=0) immediately and asynchronously; rr_ptr returns to 0.

Optional Feature:
Macro MUX_RR_FORCE_EN.
- Defined: adds ports force_en (input 1) and force_sel (input CH_W).
  - While force_en=1 the arbiter is bypassed and the grant candidate is force_sel only. in_ready[force_sel] = free & in_valid[force_sel].
  - rr_ptr is not updated by forced grants.
  - force_sel >= N_CH grants nothing.
- Undefined: ports absent; pure round-robin.

Decomposition:
- Package mux_rr_pkg: default N_CH and DATA_W constants, and a function computing CH_W with minimum 1.
- One natural sub-module, rr_arbiter: combinational rotate-priority search taking (req, ptr) and returning (found, grant index, one-hot grant).
- The top level holds the output register, rr_ptr and the force logic.

Test Plan:
1. Reset: rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately, asynchronously; after release, in_valid=4'b0001 with in_data ch0=3'h2 -> next edge out_data=3'h2, out_ch=0.
2. Round-robin: in_valid=4'b1111, data ch0..3 = 3'h2,3'h1,3'h3,3'h6, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles with matching data and out_valid held 1.
3. Backpressure: out_valid=1, out_ready=0 for 3 cycles, in_valid=4'b0110 -> in_ready=0, out_data and out_ch stable; on out_ready=1 the next grant is the channel after the held out_ch.
4. Sparse and wrap: rr_ptr=3, in_valid=4'b0101 -> grant ch0, then ch2, then ch0; confirms wrap from 3 to 0 and skipping of idle channels.
5. Pop without refill: out_valid=1, out_ready=1, in_valid=0 -> out_valid=0 next cycle, out_data and out_ch hold.
6. With MUX_RR_FORCE_EN defined:
   - force_en=1, force_sel=2, in_valid=4'b1111 -> only ch2 is granted, repeatedly, with rr_ptr unchanged.
   - force_en then 0 -> grants resume from the pre-force rr_ptr.
